// File: rtl/prog_launcher_if.sv
// prog_launcher_if
//   Bundles the batch-control and core-handshake signals of prog_launcher.
//   The master modport belongs to the launcher. The slave modport belongs to
//   the environment that drives Go and DutAck: the wrapper, core and host.
//
//   Go          environment -> launcher   start a batch
//   DutAck      core        -> launcher   program finished (core's Ack)
//   DutReset    launcher    -> core       core reset
//   DutStart    launcher    -> core       core start
//   ProgIdx     launcher    -> host       program in progress / last finished
//   CycleCount  launcher    -> host       live RUN-cycle counter
//   LastCount   launcher    -> host       cycle count of last finished program
//   CountValid  launcher    -> host       one-cycle result strobe
//   TimedOut    launcher    -> host       result was a timeout
//   Busy        launcher    -> host       batch in progress
//   Done        launcher    -> host       batch complete
interface prog_launcher_if #(
    parameter int NUM_PROGS = 3,
    parameter int CNT_W     = 16
);
    localparam int IDX_W = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

    logic             Go;
    logic             DutAck;
    logic             DutReset;
    logic             DutStart;
    logic [IDX_W-1:0] ProgIdx;
    logic [CNT_W-1:0] CycleCount;
    logic [CNT_W-1:0] LastCount;
    logic             CountValid;
    logic             TimedOut;
    logic             Busy;
    logic             Done;

    modport master (
        input  Go, DutAck,
        output DutReset, DutStart, ProgIdx, CycleCount, LastCount,
               CountValid, TimedOut, Busy, Done
    );

    modport slave (
        output Go, DutAck,
        input  DutReset, DutStart, ProgIdx, CycleCount, LastCount,
               CountValid, TimedOut, Busy, Done
    );
endinterface

// File: rtl/prog_launcher.sv
// prog_launcher
//   Host-side initiator for the core's Reset/Start/Ack program handshake.
//   It runs NUM_PROGS programs back to back. For each program it holds the
//   core in reset, pulses Start and then counts RUN cycles until Ack arrives
//   or TIMEOUT expires. It reports each result as a one-cycle CountValid
//   record.
//
//   Clk    clock; all state changes on the rising edge
//   Reset  asynchronous, active-high; clears all state immediately
//   bus    prog_launcher_if.master: Go/DutAck in; DutReset, DutStart,
//          ProgIdx, CycleCount, LastCount, CountValid, TimedOut, Busy and
//          Done out. Every output comes straight from a register.
module prog_launcher #(
    parameter int          NUM_PROGS    = 3,
    parameter int          CNT_W        = 16,
    parameter int unsigned TIMEOUT      = 50000,
    parameter int          RESET_CYCLES = 2,
    parameter int          START_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    prog_launcher_if.master       bus
);
    localparam int IDX_W  = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;
    localparam int PH_MAX = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PROGS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1  = CNT_W'(TIMEOUT - 1);
    localparam logic [PH_W-1:0]  RST_LAST    = PH_W'(RESET_CYCLES - 1);
    localparam logic [PH_W-1:0]  START_LAST  = PH_W'(START_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_START,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e           state_q;
    logic [PH_W-1:0]  phase_q;        // cycles spent so far in RST / START
    logic [IDX_W-1:0] prog_idx_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic [CNT_W-1:0] last_count_q;
    logic             count_valid_q;
    logic             timed_out_q;
    logic             dut_reset_q;
    logic             dut_start_q;
    logic             busy_q;
    logic             done_q;

    // NOTE: the clocked process uses only non-blocking assignments. Every
    // register then updates from the values that held before the edge.
    // Blocking assignments would make the outcome depend on statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            prog_idx_q    <= '0;
            cycle_count_q <= '0;
            last_count_q  <= '0;
            count_valid_q <= 1'b0;
            timed_out_q   <= 1'b0;
            dut_reset_q   <= 1'b1;
            dut_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Result strobes last for a single cycle unless RUN re-arms them.
            count_valid_q <= 1'b0;
            timed_out_q   <= 1'b0;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.Go) begin
                        state_q     <= ST_RST;
                        phase_q     <= '0;
                        prog_idx_q  <= '0;
                        dut_reset_q <= 1'b1;
                        dut_start_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end

                ST_RST: begin
                    // ProgIdx still names the finished program while its
                    // CountValid record is visible. It advances at the end
                    // of the first RST cycle that follows a result.
                    if (count_valid_q) begin
                        prog_idx_q <= prog_idx_q + IDX_W'(1);
                    end
                    if (phase_q == RST_LAST) begin
                        state_q     <= ST_START;
                        phase_q     <= '0;
                        dut_reset_q <= 1'b0;
                        dut_start_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end

                ST_START: begin
                    if (phase_q == START_LAST) begin
                        state_q       <= ST_RUN;
                        phase_q       <= '0;
                        dut_start_q   <= 1'b0;
                        cycle_count_q <= '0;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end

                ST_RUN: begin
                    // Ack is checked before the timeout, so Ack wins when both
                    // happen on the last allowed cycle. The counter stops at
                    // TIMEOUT-1 and therefore never wraps.
                    if (bus.DutAck || (cycle_count_q == TIMEOUT_M1)) begin
                        count_valid_q <= 1'b1;
                        timed_out_q   <= !bus.DutAck;
                        last_count_q  <= bus.DutAck ? cycle_count_q : TIMEOUT_CNT;
                        if (prog_idx_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_RST;
                            phase_q     <= '0;
                            dut_reset_q <= 1'b1;
                        end
                    end else begin
                        cycle_count_q <= cycle_count_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    dut_reset_q <= 1'b1;
                    dut_start_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DutReset   = dut_reset_q;
    assign bus.DutStart   = dut_start_q;
    assign bus.ProgIdx    = prog_idx_q;
    assign bus.CycleCount = cycle_count_q;
    assign bus.LastCount  = last_count_q;
    assign bus.CountValid = count_valid_q;
    assign bus.TimedOut   = timed_out_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
endmodule

// File: tb/tb_prog_launcher.sv
// tb_prog_launcher
//   Self-checking bench for prog_launcher. TIMEOUT is reduced to 24 so that
//   timeout programs stay short. Per-program result records go into a
//   scoreboard queue when the stimulus is driven. A monitor pops and compares
//   them when CountValid appears.
module tb_prog_launcher;
    localparam int NUM_PROGS    = 3;
    localparam int CNT_W        = 16;
    localparam int TIMEOUT      = 24;
    localparam int RESET_CYCLES = 2;
    localparam int START_CYCLES = 1;
    localparam int IDX_W        = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

    logic clk;
    logic rst;

    prog_launcher_if #(.NUM_PROGS(NUM_PROGS), .CNT_W(CNT_W)) bus ();

    prog_launcher #(
        .NUM_PROGS    (NUM_PROGS),
        .CNT_W        (CNT_W),
        .TIMEOUT      (TIMEOUT),
        .RESET_CYCLES (RESET_CYCLES),
        .START_CYCLES (START_CYCLES)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_expired(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] last;
        logic             to;
    } exp_t;

    exp_t sb_q[$];

    always @(negedge clk) begin
        if (!rst && bus.CountValid) begin
            if (sb_q.size() == 0) begin
                bound_expired("unexpected_countvalid");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rec_progidx", 32'(bus.ProgIdx), 32'(e.idx));
                check("rec_lastcount", 32'(bus.LastCount), 32'(e.last));
                check("rec_timedout", 32'(bus.TimedOut), 32'(e.to));
            end
        end
    end

    // ---------------- vector table ----------------
    // ack_at: RUN cycle (1-based) on which DutAck is high; 0 means never.
    typedef struct {
        int               ack_at;
        logic [CNT_W-1:0] exp_last;
        logic             exp_to;
    } vec_t;

    vec_t tbl[9];

    function automatic logic in_run();
        return bus.Busy && !bus.DutReset && !bus.DutStart;
    endfunction

    // Returns, through gap, the number of non-RUN cycles seen before RUN.
    task automatic wait_run(output int gap);
        gap = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_run()) return;
            gap++;
        end
        bound_expired("wait_run");
    endtask

    task automatic pulse_go();
        @(negedge clk);
        bus.Go = 1'b1;
        @(posedge clk);
        #1;
        bus.Go = 1'b0;
        check("go_busy", 32'(bus.Busy), 1);
        check("go_dutreset", 32'(bus.DutReset), 1);
        check("go_done", 32'(bus.Done), 0);
        check("go_progidx", 32'(bus.ProgIdx), 0);
    endtask

    task automatic run_prog(input vec_t v, input int idx, input bit last);
        int gap;
        int k_exit;
        bit exited;
        wait_run(gap);
        check("gap_cycles", 32'(gap), 32'(RESET_CYCLES + START_CYCLES));
        check("run_progidx", 32'(bus.ProgIdx), 32'(idx));
        check("run_cnt0", 32'(bus.CycleCount), 0);
        sb_q.push_back('{IDX_W'(idx), v.exp_last, v.exp_to});
        exited = 1'b0;
        k_exit = 0;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            if (k == v.ack_at) bus.DutAck = 1'b1;
            if (k == 2 && v.ack_at != 2) bus.Go = 1'b1;   // ignored in RUN
            @(posedge clk);
            #1;
            bus.DutAck = 1'b0;
            bus.Go     = 1'b0;
            if (!in_run()) begin
                exited = 1'b1;
                k_exit = k;
                break;
            end
            @(negedge clk);
        end
        if (!exited) begin
            bound_expired("run_exit");
        end else begin
            check("run_length", 32'(k_exit), 32'((v.ack_at != 0) ? v.ack_at : TIMEOUT));
            if (last) begin
                check("last_done", 32'(bus.Done), 1);
                check("last_busy", 32'(bus.Busy), 0);
                check("last_dutreset", 32'(bus.DutReset), 0);
            end else begin
                check("next_dutreset", 32'(bus.DutReset), 1);
                check("next_busy", 32'(bus.Busy), 1);
            end
        end
    endtask

    task automatic run_batch(input int b);
        pulse_go();
        for (int p = 0; p < NUM_PROGS; p++) begin
            run_prog(tbl[b * NUM_PROGS + p], p, p == NUM_PROGS - 1);
        end
        @(negedge clk);
        check("done_hold", 32'(bus.Done), 1);
        check("done_progidx", 32'(bus.ProgIdx), 32'(NUM_PROGS - 1));
        check("done_dutstart", 32'(bus.DutStart), 0);
    endtask

    initial begin
        tbl[0] = '{10, 16'd9,  1'b0};
        tbl[1] = '{20, 16'd19, 1'b0};
        tbl[2] = '{5,  16'd4,  1'b0};
        tbl[3] = '{0,  16'(TIMEOUT), 1'b1};
        tbl[4] = '{0,  16'(TIMEOUT), 1'b1};
        tbl[5] = '{0,  16'(TIMEOUT), 1'b1};
        tbl[6] = '{TIMEOUT, 16'(TIMEOUT - 1), 1'b0};
        tbl[7] = '{1,  16'd0,  1'b0};
        tbl[8] = '{TIMEOUT, 16'(TIMEOUT - 1), 1'b0};

        rst        = 1'b1;
        bus.Go     = 1'b0;
        bus.DutAck = 1'b0;
        #3;
        check("rst_dutreset", 32'(bus.DutReset), 1);
        check("rst_dutstart", 32'(bus.DutStart), 0);
        check("rst_progidx", 32'(bus.ProgIdx), 0);
        check("rst_cyclecount", 32'(bus.CycleCount), 0);
        check("rst_lastcount", 32'(bus.LastCount), 0);
        check("rst_countvalid", 32'(bus.CountValid), 0);
        check("rst_timedout", 32'(bus.TimedOut), 0);
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_done", 32'(bus.Done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_dutreset", 32'(bus.DutReset), 1);
        check("idle_busy", 32'(bus.Busy), 0);

        // Table batches: Ack-driven, all-timeout, Ack on the last allowed
        // cycle. Each later batch starts from DONE.
        for (int b = 0; b < 3; b++) run_batch(b);

        // DutAck held high from DONE onward: it is ignored until RUN, and
        // then each program ends on its first RUN cycle.
        begin
            int gap;
            bus.DutAck = 1'b1;
            pulse_go();
            for (int p = 0; p < NUM_PROGS; p++) begin
                wait_run(gap);
                check("ackhold_gap", 32'(gap), 32'(RESET_CYCLES + START_CYCLES));
                sb_q.push_back('{IDX_W'(p), '0, 1'b0});
                @(posedge clk);
                #1;
                check("ackhold_exit", 32'(in_run()), 0);
            end
            @(negedge clk);
            bus.DutAck = 1'b0;
            check("ackhold_done", 32'(bus.Done), 1);
        end

        // Reset between clock edges in the middle of RUN.
        begin
            int gap;
            pulse_go();
            wait_run(gap);
            repeat (3) @(negedge clk);
            #2;
            rst = 1'b1;
            #1;
            check("midrst_dutreset", 32'(bus.DutReset), 1);
            check("midrst_busy", 32'(bus.Busy), 0);
            check("midrst_countvalid", 32'(bus.CountValid), 0);
            check("midrst_cyclecount", 32'(bus.CycleCount), 0);
            check("midrst_lastcount", 32'(bus.LastCount), 0);
            check("midrst_progidx", 32'(bus.ProgIdx), 0);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("midrst_idle_done", 32'(bus.Done), 0);
            run_batch(0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
